// File: rtl/cpu_types_pkg.sv
// Shared CPU/bus types: words, RAM handshake states and the
// coherence controller state encoding.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE,
      BUSY,
      ACCESS,
      ERROR
   } ramstate_t;

   typedef enum logic [2:0] {
      IDLE,
      IFETCH,
      WB,
      SNOOP,
      C2C,
      RAMLD
   } cc_state_t;

endpackage

// File: rtl/cache_control_if.sv
// Bus between the per-core caches, the coherence controller
// and the RAM port.
interface cache_control_if #(
   parameter int CPUS = 2
);
   import cpu_types_pkg::*;

   logic  [CPUS-1:0] iREN;
   logic  [CPUS-1:0] dREN;
   logic  [CPUS-1:0] dWEN;
   word_t [CPUS-1:0] iaddr;
   word_t [CPUS-1:0] daddr;
   word_t [CPUS-1:0] dstore;
   logic  [CPUS-1:0] ccwrite;
   logic  [CPUS-1:0] cctrans;

   logic  [CPUS-1:0] iwait;
   logic  [CPUS-1:0] dwait;
   word_t [CPUS-1:0] iload;
   word_t [CPUS-1:0] dload;
   logic  [CPUS-1:0] ccwait;
   logic  [CPUS-1:0] ccinv;
   word_t [CPUS-1:0] ccsnoopaddr;

   word_t            ramload;
   ramstate_t        ramstate;
   logic             ramREN;
   logic             ramWEN;
   word_t            ramaddr;
   word_t            ramstore;

   modport cc (
      input  iREN, dREN, dWEN, iaddr, daddr, dstore,
      input  ccwrite, cctrans, ramload, ramstate,
      output iwait, dwait, iload, dload,
      output ccwait, ccinv, ccsnoopaddr,
      output ramREN, ramWEN, ramaddr, ramstore
   );

   modport cache (
      output iREN, dREN, dWEN, iaddr, daddr, dstore,
      output ccwrite, cctrans,
      input  iwait, dwait, iload, dload,
      input  ccwait, ccinv, ccsnoopaddr
   );

endinterface

// File: rtl/cc_arbiter.sv
// Request picker: class priority dWEN > dREN > iREN, round-robin
// between cores inside a class.
module cc_arbiter
   import cpu_types_pkg::*;
(
   input  logic       CLK,
   input  logic       nRST,
   input  logic [1:0] iren,
   input  logic [1:0] dren,
   input  logic [1:0] dwen,
   input  logic       done,
   input  logic       done_g,
   output logic       req,
   output logic       gnt,
   output cc_state_t  target
);

   logic last;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         last <= 1'b1;
      end else if (done) begin
         last <= done_g;
      end
   end

   // A tie goes to the core that was not served last.
   function automatic logic pick(
      input logic [1:0] r,
      input logic       lg
   );
      return (&r) ? ~lg : r[1];
   endfunction

   always_comb begin
      req    = 1'b1;
      gnt    = 1'b0;
      target = IDLE;
      priority case (1'b1)
         |dwen: begin
            target = WB;
            gnt    = pick(dwen, last);
         end
         |dren: begin
            target = SNOOP;
            gnt    = pick(dren, last);
         end
         |iren: begin
            target = IFETCH;
            gnt    = pick(iren, last);
         end
         default: req = 1'b0;
      endcase
   end

endmodule

// File: rtl/memory_control.sv
// Coherence bus controller: serialises both cores onto one RAM port
// and runs MSI snooping with cache-to-cache transfers.
module memory_control
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   cache_control_if.cc ccif
);

   cc_state_t   state;
   cc_state_t   nstate;
   cc_state_t   atgt;
   logic        g;
   logic        p;
   logic        areq;
   logic        agnt;
   logic        live;
   logic        acc;
   logic        done;
   logic [1:0]  iwait;
   logic [1:0]  dwait;
   logic [1:0]  ccwait;
   logic [1:0]  ccinv;
   word_t [1:0] iload;
   word_t [1:0] dload;
   word_t [1:0] snoop;
   logic        ren;
   logic        wen;
   word_t       raddr;
   word_t       rstore;

   assign p   = ~g;
   assign acc = (ccif.ramstate == ACCESS);

   cc_arbiter u_arb (
      .CLK    (CLK),
      .nRST   (nRST),
      .iren   (ccif.iREN),
      .dren   (ccif.dREN),
      .dwen   (ccif.dWEN),
      .done   (done),
      .done_g (g),
      .req    (areq),
      .gnt    (agnt),
      .target (atgt)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         g     <= 1'b0;
      end else begin
         state <= nstate;
         if (state == IDLE) begin
            g <= agnt;
         end
      end
   end

   // A transaction only stays alive while its requester holds the line.
   always_comb begin
      live = 1'b0;
      unique case (state)
         IFETCH:            live = ccif.iREN[g];
         WB:                live = ccif.dWEN[g];
         SNOOP, C2C, RAMLD: live = ccif.dREN[g];
         default:           live = 1'b0;
      endcase
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE: begin
            nstate = areq ? atgt : IDLE;
         end
         SNOOP: begin
            if (!live) begin
               nstate = IDLE;
            end else if (ccif.cctrans[p] & ccif.ccwrite[p]) begin
               nstate = C2C;
            end else begin
               nstate = RAMLD;
            end
         end
         IFETCH, WB, C2C, RAMLD: begin
            if (!live || acc) begin
               nstate = IDLE;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      iwait  = '1;
      dwait  = '1;
      iload  = '0;
      dload  = '0;
      ccwait = '0;
      ccinv  = '0;
      snoop  = '0;
      ren    = 1'b0;
      wen    = 1'b0;
      raddr  = '0;
      rstore = '0;
      done   = 1'b0;
      if (live) begin
         unique case (state)
            IFETCH: begin
               ren   = 1'b1;
               raddr = ccif.iaddr[g];
               if (acc) begin
                  iwait[g] = 1'b0;
                  iload[g] = ccif.ramload;
                  done     = 1'b1;
               end
            end
            WB: begin
               wen    = 1'b1;
               raddr  = ccif.daddr[g];
               rstore = ccif.dstore[g];
               if (acc) begin
                  dwait[g] = 1'b0;
                  done     = 1'b1;
               end
            end
            SNOOP: begin
               ccwait[p] = 1'b1;
               snoop[p]  = ccif.daddr[g];
               ccinv[p]  = ccif.ccwrite[g];
            end
            C2C: begin
               // Peer data goes to the requester and to RAM at once.
               ccwait[p] = 1'b1;
               snoop[p]  = ccif.daddr[g];
               wen       = 1'b1;
               raddr     = ccif.daddr[p];
               rstore    = ccif.dstore[p];
               if (acc) begin
                  dload[g] = ccif.dstore[p];
                  dwait[g] = 1'b0;
                  dwait[p] = 1'b0;
                  done     = 1'b1;
               end
            end
            RAMLD: begin
               ccwait[p] = 1'b1;
               snoop[p]  = ccif.daddr[g];
               ren       = 1'b1;
               raddr     = ccif.daddr[g];
               if (acc) begin
                  dload[g] = ccif.ramload;
                  dwait[g] = 1'b0;
                  done     = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ccif.iwait       = iwait;
   assign ccif.dwait       = dwait;
   assign ccif.iload       = iload;
   assign ccif.dload       = dload;
   assign ccif.ccwait      = ccwait;
   assign ccif.ccinv       = ccinv;
   assign ccif.ccsnoopaddr = snoop;
   assign ccif.ramREN      = ren;
   assign ccif.ramWEN      = wen;
   assign ccif.ramaddr     = raddr;
   assign ccif.ramstore    = rstore;

endmodule
